// File: rtl/ex_product_if.sv
// Bus between the multiplier generator and ex_product: capture strobe,
// six Q15.11 factors, and result/status back to the generator side.
interface ex_product_if #(
  parameter int OUT_W = 36
);
  logic             mul_valid;
  logic [25:0]      multiplier_0;
  logic [25:0]      multiplier_1;
  logic [25:0]      multiplier_2;
  logic [25:0]      multiplier_3;
  logic [25:0]      multiplier_4;
  logic [25:0]      multiplier_5;
  logic             busy;
  logic             out_valid;
  logic [OUT_W-1:0] result;
  logic             sat;
  logic             drop;

  modport master (
    output mul_valid, multiplier_0, multiplier_1, multiplier_2,
           multiplier_3, multiplier_4, multiplier_5,
    input  busy, out_valid, result, sat, drop
  );

  modport slave (
    input  mul_valid, multiplier_0, multiplier_1, multiplier_2,
           multiplier_3, multiplier_4, multiplier_5,
    output busy, out_valid, result, sat, drop
  );
endinterface

// File: rtl/ex_product.sv
// Iterative product of six Q15.11 factors with round-half-up normalisation
// and saturation; fixed 13-cycle latency from mul_valid to out_valid.
//
// state | meaning
// IDLE  | waiting for mul_valid; captures factors, acc = 1.0
// MUL   | prod = acc * m[idx] at full width
// NORM  | round/shift prod into acc (zero factor = identity); last idx emits
module ex_product #(
  parameter int OUT_W  = 36,
  parameter int FRAC_W = 11
) (
  input  logic         clk,
  input  logic         rst,
  ex_product_if.slave  bus
);
  localparam int PW = OUT_W + 26;
  localparam int RW = PW + 1;
  localparam int TW = RW - FRAC_W;

  typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

  state_t           state, state_nx;
  logic [25:0]      m [6];
  logic [OUT_W-1:0] acc;
  logic [2:0]       idx;
  logic [PW-1:0]    prod;
  logic             sat_flag;
  logic [OUT_W-1:0] result_q;
  logic             sat_q;
  logic             out_valid_q;
  logic             drop_q;

  logic [25:0]      m_cur;
  logic [RW-1:0]    rnd;
  logic [TW-1:0]    t;
  logic             ovf;
  logic             sat_step;
  logic [OUT_W-1:0] acc_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.mul_valid) state_nx = MUL;
      MUL:     state_nx = NORM;
      NORM:    state_nx = (idx == 3'd5) ? IDLE : MUL;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    m_cur    = m[idx];
    rnd      = {1'b0, prod} + RW'(1 << (FRAC_W - 1));
    t        = rnd[RW-1:FRAC_W];
    ovf      = |t[TW-1:OUT_W];
    sat_step = (m_cur != 26'd0) && ovf;
    acc_nx   = acc;
    if (m_cur != 26'd0)
      acc_nx = ovf ? {OUT_W{1'b1}} : t[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      idx         <= '0;
      prod        <= '0;
      sat_flag    <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      for (int i = 0; i < 6; i++) m[i] <= '0;
    end else begin
      state       <= state_nx;
      out_valid_q <= 1'b0;
      drop_q      <= bus.mul_valid && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.mul_valid) begin
            m[0]     <= bus.multiplier_0;
            m[1]     <= bus.multiplier_1;
            m[2]     <= bus.multiplier_2;
            m[3]     <= bus.multiplier_3;
            m[4]     <= bus.multiplier_4;
            m[5]     <= bus.multiplier_5;
            acc      <= OUT_W'(1) << FRAC_W;
            idx      <= '0;
            sat_flag <= 1'b0;
          end
        end
        MUL: prod <= PW'(acc) * PW'(m_cur);
        NORM: begin
          acc      <= acc_nx;
          sat_flag <= sat_flag | sat_step;
          if (idx == 3'd5) begin
            result_q    <= acc_nx;
            sat_q       <= sat_flag | sat_step;
            out_valid_q <= 1'b1;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.sat       = sat_q;
  assign bus.drop      = drop_q;
endmodule

// File: tb/tb_ex_product.sv
// Directed bench for ex_product: identity, exact, rounding, zero-skip,
// saturation, drop/back-to-back and mid-operation reset.
module tb_ex_product;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [35:0] last_result = '0;
  logic        last_sat    = 1'b0;

  localparam logic [25:0] ONE = 26'd2048;
  localparam logic [25:0] MAX = 26'h3FF_FFFF;

  ex_product_if #(.OUT_W(36)) bus ();
  ex_product #(.OUT_W(36), .FRAC_W(11)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic set_m(input logic [25:0] a, b, c, d, e, f);
    bus.multiplier_0 = a; bus.multiplier_1 = b; bus.multiplier_2 = c;
    bus.multiplier_3 = d; bus.multiplier_4 = e; bus.multiplier_5 = f;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mul_valid = 1'b0;
    set_m(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.result !== 36'd0) begin fails++; $display("FAIL reset_result got %0d want 0", bus.result); end
    tests++; if (bus.sat !== 1'b0) begin fails++; $display("FAIL reset_sat got %b want 0", bus.sat); end
    tests++; if (bus.drop !== 1'b0) begin fails++; $display("FAIL reset_drop got %b want 0", bus.drop); end
    rst = 1'b0;
  endtask

  // One full operation with per-cycle busy/out_valid/hold/drop checks.
  task automatic run_op(input string name, input logic [25:0] a, b, c, d, e, f,
                        input logic [35:0] er, input logic es);
    @(posedge clk); #1;
    set_m(a, b, c, d, e, f);
    bus.mul_valid = 1'b1;
    for (int cy = 1; cy <= 13; cy++) begin
      @(posedge clk); #1;
      if (cy == 1) begin bus.mul_valid = 1'b0; set_m(0, 0, 0, 0, 0, 0); end
      tests++; if (bus.busy !== (cy <= 12)) begin fails++; $display("FAIL %s busy cycle %0d got %b want %b", name, cy, bus.busy, (cy <= 12)); end
      tests++; if (bus.out_valid !== (cy == 13)) begin fails++; $display("FAIL %s out_valid cycle %0d got %b want %b", name, cy, bus.out_valid, (cy == 13)); end
      tests++; if (bus.drop !== 1'b0) begin fails++; $display("FAIL %s drop cycle %0d got %b want 0", name, cy, bus.drop); end
      if (cy < 13) begin
        tests++; if (bus.result !== last_result || bus.sat !== last_sat) begin fails++; $display("FAIL %s hold cycle %0d got %0d/%b want %0d/%b", name, cy, bus.result, bus.sat, last_result, last_sat); end
      end
    end
    tests++; if (bus.result !== er) begin fails++; $display("FAIL %s result got %0d want %0d", name, bus.result, er); end
    tests++; if (bus.sat !== es) begin fails++; $display("FAIL %s sat got %b want %b", name, bus.sat, es); end
    last_result = er;
    last_sat    = es;
  endtask

  task automatic test_identity();
    run_op("identity", ONE, ONE, ONE, ONE, ONE, ONE, 36'd2048, 1'b0);
  endtask

  task automatic test_exact();
    run_op("exact", 26'd4096, 26'd3072, ONE, ONE, ONE, ONE, 36'd6144, 1'b0);
  endtask

  task automatic test_rounding();
    run_op("rounding", 26'd2049, 26'd2049, ONE, ONE, ONE, ONE, 36'd2050, 1'b0);
  endtask

  task automatic test_zero_skip();
    run_op("zero_skip", 26'd6144, 0, 0, 0, 0, 0, 36'd6144, 1'b0);
  endtask

  task automatic test_saturation();
    run_op("saturation", MAX, MAX, MAX, MAX, MAX, MAX, 36'hF_FFFF_FFFF, 1'b1);
    run_op("after_sat", ONE, ONE, ONE, ONE, ONE, ONE, 36'd2048, 1'b0);
  endtask

  // Drop at cycle 5 -> pulse at 6; new op accepted exactly at cycle 13.
  task automatic test_back_to_back();
    @(posedge clk); #1;
    set_m(26'd4096, 26'd3072, ONE, ONE, ONE, ONE);
    bus.mul_valid = 1'b1;
    for (int cy = 1; cy <= 26; cy++) begin
      @(posedge clk); #1;
      tests++; if (bus.busy !== ((cy <= 12) || (cy >= 14 && cy <= 25))) begin fails++; $display("FAIL b2b busy cycle %0d got %b", cy, bus.busy); end
      tests++; if (bus.out_valid !== (cy == 13 || cy == 26)) begin fails++; $display("FAIL b2b out_valid cycle %0d got %b", cy, bus.out_valid); end
      tests++; if (bus.drop !== (cy == 6)) begin fails++; $display("FAIL b2b drop cycle %0d got %b want %b", cy, bus.drop, (cy == 6)); end
      if (cy == 13) begin
        tests++; if (bus.result !== 36'd6144 || bus.sat !== 1'b0) begin fails++; $display("FAIL b2b first result got %0d/%b want 6144/0", bus.result, bus.sat); end
      end
      if (cy == 26) begin
        tests++; if (bus.result !== 36'd2048 || bus.sat !== 1'b0) begin fails++; $display("FAIL b2b second result got %0d/%b want 2048/0", bus.result, bus.sat); end
      end
      bus.mul_valid = (cy == 5) || (cy == 13);
      if (cy == 5)  set_m(MAX, MAX, MAX, MAX, MAX, MAX);
      else if (cy == 13) set_m(ONE, ONE, ONE, ONE, ONE, ONE);
      else set_m(0, 0, 0, 0, 0, 0);
    end
    last_result = 36'd2048;
    last_sat    = 1'b0;
  endtask

  // Reset at cycle 7 (with a mul_valid that must be ignored).
  task automatic test_mid_reset();
    @(posedge clk); #1;
    set_m(26'd4096, ONE, ONE, ONE, ONE, ONE);
    bus.mul_valid = 1'b1;
    for (int cy = 1; cy <= 7; cy++) begin
      @(posedge clk); #1;
      bus.mul_valid = 1'b0;
      tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mid_reset busy cycle %0d got %b want 1", cy, bus.busy); end
    end
    rst = 1'b1;
    bus.mul_valid = 1'b1;
    @(posedge clk); #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_reset busy got %b want 0", bus.busy); end
    tests++; if (bus.result !== 36'd0) begin fails++; $display("FAIL mid_reset result got %0d want 0", bus.result); end
    tests++; if (bus.sat !== 1'b0 || bus.drop !== 1'b0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset flags got sat=%b drop=%b ov=%b want 0", bus.sat, bus.drop, bus.out_valid); end
    rst = 1'b0;
    bus.mul_valid = 1'b0;
    for (int cy = 9; cy <= 22; cy++) begin
      @(posedge clk); #1;
      tests++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 36'd0) begin fails++; $display("FAIL mid_reset after cycle %0d got ov=%b busy=%b result=%0d want 0", cy, bus.out_valid, bus.busy, bus.result); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_exact();
    test_rounding();
    test_zero_skip();
    test_saturation();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
